// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Issue-side register scoreboard for the decode stage. Counts in-flight writers per
//   register and stalls ID on a RAW hazard against an un-retired writer, or when issuing
//   would overflow a saturated writer counter. Writeback retirements decrement the counters.
//
// Ports
//   clk        pipeline clock
//   reset      synchronous, active-high reset; overrides flush, issue and release
//   id_valid   ID presents an instruction this cycle
//   id_req     source-register mask of the ID instruction
//   id_prov    destination-register mask of the ID instruction
//   id_stall   ID must hold; the instruction is not accepted this cycle
//   wb_valid   writeback retires an instruction this cycle
//   wb_prov    destination mask being retired
//   flush      discard all in-flight writer state (branch redirect)
//   busy       bit i set when register i has at least one in-flight writer
//   sb_err     sticky: a release hit a register with no in-flight writer
//   stall_cnt  saturating count of cycles with id_stall asserted
module reg_scoreboard #(
    parameter int unsigned NREGS  = 16,
    parameter int unsigned CNT_W  = 2,
    parameter int unsigned STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [NREGS-1:0]  id_req,
    input  logic [NREGS-1:0]  id_prov,
    output logic              id_stall,
    input  logic              wb_valid,
    input  logic [NREGS-1:0]  wb_prov,
    input  logic              flush,
    output logic [NREGS-1:0]  busy,
    output logic              sb_err,
    output logic [STAT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0]  CntMax  = {CNT_W{1'b1}};
    localparam logic [STAT_W-1:0] StatMax = {STAT_W{1'b1}};

    logic [NREGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                        err_q, err_d;
    logic [STAT_W-1:0]           stall_q, stall_d;

    logic [NREGS-1:0] cnt_full;
    logic [NREGS-1:0] inc_vec;
    logic [NREGS-1:0] rel_vec;
    logic             issue;
    logic             rel;

    // Per-register status derived from the registered counters only, so a release
    // never unstalls ID in the same cycle it is reported.
    always_comb begin
        busy     = '0;
        cnt_full = '0;
        for (int i = 0; i < NREGS; i++) begin
            busy[i]     = |cnt_q[i];
            cnt_full[i] = (cnt_q[i] == CntMax);
        end
    end

    // Stall on RAW against any in-flight writer, or on a destination whose writer
    // counter is already saturated. Plain WAW below saturation is allowed.
    assign id_stall = id_valid & ((|(id_req & busy)) | (|(id_prov & cnt_full)));

    assign issue   = id_valid & ~id_stall & ~flush;
    assign rel     = wb_valid & ~flush;
    assign inc_vec = {NREGS{issue}} & id_prov;
    assign rel_vec = {NREGS{rel}} & wb_prov;

    always_comb begin
        cnt_d   = cnt_q;
        err_d   = err_q;
        stall_d = stall_q;

        for (int i = 0; i < NREGS; i++) begin
            if (inc_vec[i] && rel_vec[i]) begin
                // Issue and release of the same register cancel, even at 0 or full;
                // no error is flagged because the release is matched by the issue.
                cnt_d[i] = cnt_q[i];
            end else if (inc_vec[i]) begin
                // Cannot overflow: a full counter stalls the issue.
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (rel_vec[i]) begin
                if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end else begin
                    err_d = 1'b1;
                end
            end
        end

        // flush already masks issue/release above; it additionally clears everything.
        if (flush) begin
            cnt_d = '0;
        end

        if (id_stall && (stall_q != StatMax)) begin
            stall_d = stall_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    assign sb_err    = err_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard
//   Directed-vector bench for reg_scoreboard. The driver applies one vector per cycle
//   (1 time unit after the rising edge) and queues the values each output must show in
//   that cycle; a monitor samples on the falling edge and checks every queued entry.
//   STAT_W is reduced to 4 so stall-counter saturation is reachable quickly.
module tb_reg_scoreboard;

    localparam int unsigned NREGS  = 16;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned STAT_W = 4;

    localparam int F_STALL = 0;
    localparam int F_BUSY  = 1;
    localparam int F_ERR   = 2;
    localparam int F_SCNT  = 3;

    logic              clk;
    logic              reset;
    logic              id_valid;
    logic [NREGS-1:0]  id_req;
    logic [NREGS-1:0]  id_prov;
    logic              id_stall;
    logic              wb_valid;
    logic [NREGS-1:0]  wb_prov;
    logic              flush;
    logic [NREGS-1:0]  busy;
    logic              sb_err;
    logic [STAT_W-1:0] stall_cnt;

    reg_scoreboard #(
        .NREGS  (NREGS),
        .CNT_W  (CNT_W),
        .STAT_W (STAT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .id_valid  (id_valid),
        .id_req    (id_req),
        .id_prov   (id_prov),
        .id_stall  (id_stall),
        .wb_valid  (wb_valid),
        .wb_prov   (wb_prov),
        .flush     (flush),
        .busy      (busy),
        .sb_err    (sb_err),
        .stall_cnt (stall_cnt)
    );

    typedef struct {
        int          cyc;
        int          fld;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   n_cmp;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int fld);
        case (fld)
            F_STALL: actual = {31'd0, id_stall};
            F_BUSY:  actual = {16'd0, busy};
            F_ERR:   actual = {31'd0, sb_err};
            default: actual = {28'd0, stall_cnt};
        endcase
    endfunction

    // Monitor: checks every expectation queued for the current cycle (or earlier).
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] a;
            e = exp_q.pop_front();
            a = actual(e.fld);
            n_cmp++;
            if (a !== e.val) begin
                n_fail++;
                $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", e.tag, cyc, a, e.val);
            end
        end
    end

    task automatic step(input logic v, input logic [15:0] req, input logic [15:0] prov,
                        input logic wv, input logic [15:0] wp, input logic fl,
                        input logic rst);
        @(posedge clk);
        #1;
        id_valid = v;
        id_req   = req;
        id_prov  = prov;
        wb_valid = wv;
        wb_prov  = wp;
        flush    = fl;
        reset    = rst;
    endtask

    task automatic expect_val(input int fld, input logic [31:0] val, input string tag);
        exp_t e;
        e.cyc = cyc;
        e.fld = fld;
        e.val = val;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        reset    = 1'b1;
        id_valid = 1'b0;
        id_req   = '0;
        id_prov  = '0;
        wb_valid = 1'b0;
        wb_prov  = '0;
        flush    = 1'b0;

        step(0, 16'h0, 16'h0, 0, 16'h0, 0, 1);
        step(0, 16'h0, 16'h0, 0, 16'h0, 0, 1);

        // 1: reset state, then a hazard-free issue of r2.
        step(1, 16'h0002, 16'h0004, 0, 16'h0, 0, 0);
        expect_val(F_BUSY, 32'h0, "reset_busy");
        expect_val(F_ERR, 32'h0, "reset_err");
        expect_val(F_SCNT, 32'h0, "reset_scnt");
        expect_val(F_STALL, 32'h0, "t1_no_stall");

        // 2: RAW on r2, release has no same-cycle bypass.
        step(1, 16'h0004, 16'h0, 0, 16'h0, 0, 0);
        expect_val(F_BUSY, 32'h0004, "t1_busy");
        expect_val(F_STALL, 32'h1, "t2_raw_stall");
        expect_val(F_SCNT, 32'h0, "t2_scnt0");
        step(1, 16'h0004, 16'h0, 1, 16'h0004, 0, 0);
        expect_val(F_STALL, 32'h1, "t2_stall_in_rel_cycle");
        expect_val(F_SCNT, 32'h1, "t2_scnt1");
        step(1, 16'h0004, 16'h0, 0, 16'h0, 0, 0);
        expect_val(F_STALL, 32'h0, "t2_unstall");
        expect_val(F_BUSY, 32'h0, "t2_busy_clear");
        expect_val(F_SCNT, 32'h2, "t2_scnt2");

        // 3: three writers to r3 saturate the counter; WAW below saturation is free.
        step(1, 16'h0, 16'h0008, 0, 16'h0, 0, 0);
        expect_val(F_STALL, 32'h0, "t3_issue1");
        step(1, 16'h0, 16'h0008, 0, 16'h0, 0, 0);
        expect_val(F_STALL, 32'h0, "t3_waw_no_stall");
        expect_val(F_BUSY, 32'h0008, "t3_busy");
        step(1, 16'h0, 16'h0008, 0, 16'h0, 0, 0);
        expect_val(F_STALL, 32'h0, "t3_issue3");
        step(1, 16'h0, 16'h0008, 1, 16'h0008, 0, 0);
        expect_val(F_STALL, 32'h1, "t3_full_stall");
        step(1, 16'h0, 16'h0008, 0, 16'h0, 0, 0);
        expect_val(F_STALL, 32'h0, "t3_issue_after_rel");
        expect_val(F_SCNT, 32'h3, "t3_scnt");
        step(1, 16'h0, 16'h0008, 0, 16'h0, 0, 0);
        expect_val(F_STALL, 32'h1, "t3_full_again");
        // id_valid=0 forces no stall even with a full destination; drain r3.
        step(0, 16'h0, 16'h0008, 1, 16'h0008, 0, 0);
        expect_val(F_STALL, 32'h0, "t3_invalid_no_stall");
        expect_val(F_SCNT, 32'h4, "t3_scnt4");
        step(0, 16'h0, 16'h0, 1, 16'h0008, 0, 0);
        step(0, 16'h0, 16'h0, 1, 16'h0008, 0, 0);
        step(0, 16'h0, 16'h0, 0, 16'h0, 0, 0);
        expect_val(F_BUSY, 32'h0, "t3_drained");
        expect_val(F_ERR, 32'h0, "t3_no_err");

        // 4: same-cycle issue and release of r4 nets to zero change.
        step(1, 16'h0, 16'h0010, 0, 16'h0, 0, 0);
        step(1, 16'h0, 16'h0010, 1, 16'h0010, 0, 0);
        expect_val(F_BUSY, 32'h0010, "t4_busy_before");
        expect_val(F_STALL, 32'h0, "t4_no_stall");
        step(0, 16'h0, 16'h0, 1, 16'h0010, 0, 0);
        expect_val(F_BUSY, 32'h0010, "t4_busy_kept");
        expect_val(F_ERR, 32'h0, "t4_no_err");
        // Same-cycle issue/release on an idle register: no error.
        step(1, 16'h0, 16'h0020, 1, 16'h0020, 0, 0);
        expect_val(F_BUSY, 32'h0, "t4_cnt_was_one");
        expect_val(F_ERR, 32'h0, "t4_no_err_after_rel");
        step(0, 16'h0, 16'h0, 0, 16'h0, 0, 0);
        expect_val(F_BUSY, 32'h0, "t4_zero_net");
        expect_val(F_ERR, 32'h0, "t4_zero_no_err");

        // 5: releasing an idle register sets the sticky error.
        step(0, 16'h0, 16'h0, 1, 16'h0100, 0, 0);
        step(0, 16'h0, 16'h0, 0, 16'h0, 0, 0);
        expect_val(F_ERR, 32'h1, "t5_err_set");
        expect_val(F_BUSY, 32'h0, "t5_busy_unchanged");
        step(0, 16'h0, 16'h0, 0, 16'h0, 0, 0);
        expect_val(F_ERR, 32'h1, "t5_err_sticky");

        // 6: flush clears everything except sb_err and stall_cnt.
        step(1, 16'h0, 16'h00FF, 0, 16'h0, 0, 0);
        step(1, 16'h0, 16'h0100, 1, 16'h0001, 1, 0);
        expect_val(F_BUSY, 32'h00FF, "t6_busy_ff");
        expect_val(F_STALL, 32'h0, "t6_flush_cycle_stall");
        step(0, 16'h0, 16'h0, 0, 16'h0, 0, 0);
        expect_val(F_BUSY, 32'h0, "t6_flushed");
        expect_val(F_ERR, 32'h1, "t6_err_kept");
        expect_val(F_SCNT, 32'h4, "t6_scnt_kept");
        step(1, 16'h0, 16'h0001, 0, 16'h0, 0, 0);
        step(1, 16'h0001, 16'h0, 0, 16'h0, 1, 0);
        expect_val(F_STALL, 32'h1, "t6_stall_during_flush");
        step(1, 16'h0001, 16'h0, 0, 16'h0, 0, 0);
        expect_val(F_STALL, 32'h0, "t6_stall_after_flush");
        expect_val(F_SCNT, 32'h5, "t6_scnt_counted");

        // Reset mid-stall.
        step(1, 16'h0, 16'h0002, 0, 16'h0, 0, 0);
        step(1, 16'h0002, 16'h0, 0, 16'h0, 0, 0);
        expect_val(F_STALL, 32'h1, "t6_pre_reset_stall");
        step(1, 16'h0002, 16'h0, 0, 16'h0, 0, 1);
        expect_val(F_SCNT, 32'h6, "t6_pre_reset_scnt");
        step(1, 16'h0002, 16'h0, 0, 16'h0, 0, 0);
        expect_val(F_STALL, 32'h0, "t6_post_reset_stall");
        expect_val(F_SCNT, 32'h0, "t6_post_reset_scnt");
        expect_val(F_ERR, 32'h0, "t6_post_reset_err");
        expect_val(F_BUSY, 32'h0, "t6_post_reset_busy");

        // Stall counter saturation at 2**STAT_W-1.
        step(1, 16'h0, 16'h0002, 0, 16'h0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 16'h0002, 16'h0, 0, 16'h0, 0, 0);
        end
        expect_val(F_STALL, 32'h1, "sat_still_stalling");
        step(0, 16'h0, 16'h0, 0, 16'h0, 0, 0);
        expect_val(F_SCNT, 32'hF, "sat_scnt");

        // Let the monitor drain the queue within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
